// File: rtl/sobel_lb_if.sv
// Pixel-in / three-tap-out bus between a raster source and sobel_line_buffer.
// SOBEL_LB_SOF_EN adds the sof_i start-of-frame qualifier.
interface sobel_lb_if;
    localparam int unsigned PIX_W = 8;

    logic [PIX_W-1:0] pixel_i;
    logic             valid_i;
    logic             ready_o;
    logic [PIX_W-1:0] d0_o;
    logic [PIX_W-1:0] d1_o;
    logic [PIX_W-1:0] d2_o;
    logic             done_o;
    logic             frame_done_o;
`ifdef SOBEL_LB_SOF_EN
    logic             sof_i;

    modport master (output pixel_i, valid_i, sof_i,
                    input  ready_o, d0_o, d1_o, d2_o, done_o, frame_done_o);
    modport slave  (input  pixel_i, valid_i, sof_i,
                    output ready_o, d0_o, d1_o, d2_o, done_o, frame_done_o);
`else
    modport master (output pixel_i, valid_i,
                    input  ready_o, d0_o, d1_o, d2_o, done_o, frame_done_o);
    modport slave  (input  pixel_i, valid_i,
                    output ready_o, d0_o, d1_o, d2_o, done_o, frame_done_o);
`endif
endinterface

// File: rtl/sobel_line_buffer.sv
// Two-line buffer turning a raster pixel stream into vertically aligned 3-row taps.
// Optional SOBEL_LB_SOF_EN: an accepted beat with sof_i restarts the frame at (0,0).
module sobel_line_buffer #(
    parameter int unsigned ROWS = 480,
    parameter int unsigned COLS = 640,
    parameter int unsigned CW   = 10
) (
    input  logic       clk,
    input  logic       rst,
    sobel_lb_if.slave  bus
);
    localparam int unsigned PIX_W = 8;
    localparam int unsigned AW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [CW-1:0] ROW_MAX = CW'(ROWS - 1);

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    in_col, in_row, col_next, row_next;
    logic [CW-1:0]    eff_col_c, eff_row_c;
    logic             accept_c, sof_c;
    logic [PIX_W-1:0] l1_rd_c, l2_rd_c;

    logic             ready_q, done_q, frame_done_q, last_flush_q;
    logic [PIX_W-1:0] d0_q, d1_q, d2_q;
    logic             done_next, last_flush_next;
    logic [PIX_W-1:0] d0_next, d1_next, d2_next;

    logic [PIX_W-1:0] line1 [COLS];
    logic [PIX_W-1:0] line2 [COLS];

    // Next-state, counters and tap values
    always_comb begin
        state_next      = state;
        col_next        = in_col;
        row_next        = in_row;
        d0_next         = d0_q;
        d1_next         = d1_q;
        d2_next         = d2_q;
        done_next       = 1'b0;
        last_flush_next = 1'b0;
        accept_c        = bus.valid_i && ready_q;
        sof_c           = 1'b0;
`ifdef SOBEL_LB_SOF_EN
        sof_c           = accept_c && bus.sof_i;
`endif
        eff_col_c       = sof_c ? '0 : in_col;
        eff_row_c       = sof_c ? '0 : in_row;
        l1_rd_c         = line1[AW'(eff_col_c)];
        l2_rd_c         = line2[AW'(eff_col_c)];

        case (state)
            FILL, STREAM: begin
                if (accept_c) begin
                    d0_next   = bus.pixel_i;
                    d1_next   = (eff_row_c != '0) ? l1_rd_c : '0;
                    d2_next   = (eff_row_c > CW'(1)) ? l2_rd_c : '0;
                    done_next = (eff_row_c != '0);
                    if (eff_col_c == COL_MAX) begin
                        col_next = '0;
                        if (eff_row_c == ROW_MAX) begin
                            row_next   = eff_row_c;
                            state_next = FLUSH;
                        end else begin
                            row_next   = eff_row_c + CW'(1);
                            state_next = STREAM;
                        end
                    end else begin
                        col_next   = eff_col_c + CW'(1);
                        row_next   = eff_row_c;
                        state_next = (eff_row_c == '0) ? FILL : STREAM;
                    end
                end
            end
            FLUSH: begin
                // in_row stays at ROWS-1 here, so a one-row image keeps the top tap at zero
                d0_next   = '0;
                d1_next   = l1_rd_c;
                d2_next   = (in_row != '0) ? l2_rd_c : '0;
                done_next = 1'b1;
                if (in_col == COL_MAX) begin
                    col_next        = '0;
                    row_next        = '0;
                    last_flush_next = 1'b1;
                    state_next      = FILL;
                end else begin
                    col_next = in_col + CW'(1);
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            in_col       <= '0;
            in_row       <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            frame_done_q <= 1'b0;
            last_flush_q <= 1'b0;
            d0_q         <= '0;
            d1_q         <= '0;
            d2_q         <= '0;
        end else begin
            state        <= state_next;
            in_col       <= col_next;
            in_row       <= row_next;
            ready_q      <= (state_next != FLUSH);
            done_q       <= done_next;
            last_flush_q <= last_flush_next;
            frame_done_q <= last_flush_q;
            d0_q         <= d0_next;
            d1_q         <= d1_next;
            d2_q         <= d2_next;
        end
    end

    // Line memories shift down one row per accepted beat; contents are never cleared
    always_ff @(posedge clk) begin
        if (accept_c) begin
            line2[AW'(eff_col_c)] <= l1_rd_c;
            line1[AW'(eff_col_c)] <= bus.pixel_i;
        end
    end

    assign bus.ready_o      = ready_q;
    assign bus.done_o       = done_q;
    assign bus.frame_done_o = frame_done_q;
    assign bus.d0_o         = d0_q;
    assign bus.d1_o         = d1_q;
    assign bus.d2_o         = d2_q;
endmodule

// File: tb/tb_sobel_line_buffer.sv
// Randomized self-checking bench: a 4x5 instance against a frame-level reference
// model, plus a 1x3 instance for the single-row case.
module tb_sobel_line_buffer;
    localparam int unsigned A_ROWS = 4;
    localparam int unsigned A_COLS = 5;
    localparam int unsigned A_N    = A_ROWS * A_COLS;
    localparam int unsigned B_ROWS = 1;
    localparam int unsigned B_COLS = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_lb_if ba ();
    sobel_lb_if bb ();

    sobel_line_buffer #(.ROWS(A_ROWS), .COLS(A_COLS), .CW(10)) dut_a (
        .clk (clk), .rst (rst), .bus (ba.slave));
    sobel_line_buffer #(.ROWS(B_ROWS), .COLS(B_COLS), .CW(10)) dut_b (
        .clk (clk), .rst (rst), .bus (bb.slave));

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       last;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      b_got[$];
    logic [7:0] img [A_N];
    int         n_vec = 0;
    int         n_err = 0;
    bit         fd_pend = 1'b0;
    int         low_run = 0;
    int         b_fd = 0;
`ifdef SOBEL_LB_SOF_EN
    bit         sof_req = 1'b0;
`endif

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input logic [7:0] d0, input logic [7:0] d1,
                                 input logic [7:0] d2, input logic last);
        beat_t e;
        e.d0 = d0; e.d1 = d1; e.d2 = d2; e.last = last;
        return e;
    endfunction

    // Reference: one beat per pixel of rows 1..R-1, then one zero-bottom row
    task automatic push_frame_exp();
        for (int r = 1; r < int'(A_ROWS); r++)
            for (int c = 0; c < int'(A_COLS); c++)
                exp_q.push_back(mk(img[r*A_COLS + c], img[(r-1)*A_COLS + c],
                                   (r >= 2) ? img[(r-2)*A_COLS + c] : 8'd0, 1'b0));
        for (int c = 0; c < int'(A_COLS); c++)
            exp_q.push_back(mk(8'd0, img[(A_ROWS-1)*A_COLS + c],
                               img[(A_ROWS-2)*A_COLS + c], c == int'(A_COLS) - 1));
    endtask

    task automatic drive_px(input logic [7:0] p, input int gap_pct);
        int waitc = 0;
        @(negedge clk);
        while (int'($urandom_range(99)) < gap_pct) @(negedge clk);
        while (!ba.ready_o) begin
            waitc++;
            if (waitc > 100) begin
                check("ready_timeout", 32'(ba.ready_o), 1);
                return;
            end
            @(negedge clk);
        end
        ba.valid_i = 1'b1;
        ba.pixel_i = p;
`ifdef SOBEL_LB_SOF_EN
        ba.sof_i   = sof_req;
`endif
        @(posedge clk);
        #1;
        ba.valid_i = 1'b0;
`ifdef SOBEL_LB_SOF_EN
        ba.sof_i   = 1'b0;
`endif
    endtask

    task automatic send_frame(input int gap_pct, input bit seq);
        for (int i = 0; i < int'(A_N); i++)
            img[i] = seq ? 8'(i + 1) : 8'($urandom_range(255));
        push_frame_exp();
        for (int i = 0; i < int'(A_N); i++) drive_px(img[i], gap_pct);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || fd_pend) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("drain_timeout", 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_d0"}, 32'(ba.d0_o), 0);
        check({tag, "_d1"}, 32'(ba.d1_o), 0);
        check({tag, "_d2"}, 32'(ba.d2_o), 0);
        check({tag, "_done"}, 32'(ba.done_o), 0);
        check({tag, "_frame_done"}, 32'(ba.frame_done_o), 0);
        check({tag, "_ready"}, 32'(ba.ready_o), 1);
    endtask

    task automatic monitor_a();
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                low_run = 0;
                fd_pend = 1'b0;
                continue;
            end
            if (ba.frame_done_o || fd_pend) check("frame_done", 32'(ba.frame_done_o), 32'(fd_pend));
            fd_pend = 1'b0;
            if (ba.done_o) begin
                if (exp_q.size() == 0) check("spurious_done", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("d0", 32'(ba.d0_o), 32'(e.d0));
                    check("d1", 32'(ba.d1_o), 32'(e.d1));
                    check("d2", 32'(ba.d2_o), 32'(e.d2));
                    fd_pend = e.last;
                end
            end
            if (!ba.ready_o) low_run++;
            else begin
                if (low_run != 0) check("ready_low_cycles", 32'(low_run), A_COLS);
                low_run = 0;
            end
        end
    endtask

    task automatic monitor_b();
        forever begin
            @(negedge clk);
            if (!rst && bb.done_o) b_got.push_back(mk(bb.d0_o, bb.d1_o, bb.d2_o, 1'b0));
            if (!rst && bb.frame_done_o) b_fd++;
        end
    endtask

    initial begin
        ba.valid_i = 1'b0; ba.pixel_i = '0;
        bb.valid_i = 1'b0; bb.pixel_i = '0;
`ifdef SOBEL_LB_SOF_EN
        ba.sof_i = 1'b0; bb.sof_i = 1'b0;
`endif
        rst = 1'b1;
        fork
            monitor_a();
            monitor_b();
            begin
                #500000;
                $display("FAIL watchdog: run did not complete, got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        reset_checks("por");
        @(posedge clk);
        #1 rst = 1'b0;

        // Sequential frame 1..20, gap-free, then the same values with gaps
        send_frame(0, 1'b1);
        send_frame(50, 1'b1);
        wait_drain();

        // Two back-to-back random frames with ~50% valid duty
        send_frame(50, 1'b0);
        send_frame(50, 1'b0);
        wait_drain();

        // Reset while the third flush beat is being computed
        send_frame(0, 1'b1);
        @(negedge clk);
        check("ready_in_flush", 32'(ba.ready_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        reset_checks("mid_flush");
        exp_q.delete();
        fd_pend = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        send_frame(0, 1'b1);
        wait_drain();

        for (int f = 0; f < 3; f++) send_frame(30, 1'b0);
        wait_drain();

`ifdef SOBEL_LB_SOF_EN
        // Seven pixels of a frame, then an 8th beat with sof_i restarting at (0,0)
        for (int i = 0; i < 7; i++) img[i] = 8'($urandom_range(255));
        exp_q.push_back(mk(img[5], img[0], 8'd0, 1'b0));
        exp_q.push_back(mk(img[6], img[1], 8'd0, 1'b0));
        for (int i = 0; i < 7; i++) drive_px(img[i], 0);
        for (int i = 0; i < int'(A_N); i++) img[i] = 8'($urandom_range(255));
        push_frame_exp();
        for (int i = 0; i < int'(A_N); i++) begin
            sof_req = (i == 0);
            drive_px(img[i], 0);
        end
        sof_req = 1'b0;
        wait_drain();
`endif

        // Single-row image on the second instance
        for (int i = 0; i < int'(B_COLS); i++) begin
            @(negedge clk);
            bb.valid_i = 1'b1;
            bb.pixel_i = 8'(7 + i);
            @(posedge clk);
            #1 bb.valid_i = 1'b0;
        end
        repeat (10) @(negedge clk);
        check("b_beats", 32'(b_got.size()), B_COLS);
        for (int i = 0; i < b_got.size() && i < int'(B_COLS); i++) begin
            check("b_d0", 32'(b_got[i].d0), 0);
            check("b_d1", 32'(b_got[i].d1), 32'(7 + i));
            check("b_d2", 32'(b_got[i].d2), 0);
        end
        check("b_frame_done", 32'(b_fd), 1);
        check("a_queue_empty", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
